digit_roller: RTL and testbench

Parametrised successor to the four-digit rolling display. It holds NUM_DIGITS hex digits and permutes them on each step: rotate left, rotate right, or swap adjacent pairs. Steps come from an internal prescaled tick or a manual step pulse. Each digit drives one active-low seven-segment display, so the block sits between board switches/keys and the HEX outputs.

---
 rtl/roller_pkg.sv | 36 +++
 rtl/hex7seg.sv | 12 +
 rtl/digit_roller.sv | 100 ++++++++++
 tb/tb_digit_roller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/roller_pkg.sv
// Shared definitions for digit display blocks: step mode encoding and the
// active-low seven-segment pattern table used by every HEX driver.
package roller_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    ROT_L = 2'b01,
    ROT_R = 2'b10,
    SWAP  = 2'b11
  } roller_mode_e;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder; the caller
// registers the result.
module hex7seg
  import roller_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_encode(i_digit);

endmodule

// File: rtl/digit_roller.sv
// Holds NUM_DIGITS hex digits, permutes them on prescaled ticks or manual
// steps, and drives one registered active-low seven-segment output per digit.
module digit_roller
  import roller_pkg::*;
#(
  parameter int unsigned                 NUM_DIGITS  = 4,
  parameter int unsigned                 TICK_DIV    = 50_000_000,
  parameter logic [NUM_DIGITS*4-1:0]     RESET_VALUE = 16'h0123,
  parameter int unsigned                 CNT_W       = 8
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  input  logic                      run,
  input  logic                      step,
  input  logic [1:0]                mode,
  input  logic                      load,
  input  logic [NUM_DIGITS*4-1:0]   load_data,
  output logic [NUM_DIGITS*4-1:0]   digits,
  output logic [NUM_DIGITS*7-1:0]   hex,
  output logic                      tick,
  output logic [CNT_W-1:0]          step_count
);

  localparam int unsigned DW     = NUM_DIGITS * 4;
  localparam int unsigned SW     = NUM_DIGITS * 7;
  localparam int unsigned PCNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);

  logic [DW-1:0]     r_digits;
  logic [PCNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [SW-1:0]     r_hex;

  roller_mode_e      w_mode;
  logic              w_tick;
  logic              w_step_evt;
  logic              w_apply;
  logic [DW-1:0]     w_perm;
  logic [SW-1:0]     w_seg;

  assign w_mode     = roller_mode_e'(mode);
  assign w_tick     = run & (r_pcnt == PCNT_MAX);
  assign w_step_evt = w_tick | step;
  assign w_apply    = w_step_evt & (w_mode != HOLD);

  always_comb begin
    w_perm = r_digits;
    case (w_mode)
      ROT_L: w_perm = {r_digits[DW-5:0], r_digits[DW-1:DW-4]};
      ROT_R: w_perm = {r_digits[3:0], r_digits[DW-1:4]};
      SWAP: begin
        // With an odd digit count the top digit has no partner and stays put.
        for (int unsigned k = 0; k + 1 < NUM_DIGITS; k += 2) begin
          w_perm[4*k +: 4]     = r_digits[4*(k+1) +: 4];
          w_perm[4*(k+1) +: 4] = r_digits[4*k +: 4];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_digits <= RESET_VALUE;
      r_pcnt   <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_digits <= load_data;
      r_pcnt   <= '0;
      r_cnt    <= '0;
    end else begin
      if (run)
        r_pcnt <= (r_pcnt == PCNT_MAX) ? '0 : r_pcnt + 1'b1;
      if (w_step_evt)
        r_digits <= w_perm;
      if (w_apply)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7seg u_dec (
      .i_digit (r_digits[4*g +: 4]),
      .o_seg   (w_seg[7*g +: 7])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)
      r_hex <= '1;
    else
      r_hex <= w_seg;
  end

  assign digits     = r_digits;
  assign hex        = r_hex;
  assign tick       = w_tick;
  assign step_count = r_cnt;

endmodule

// File: tb/tb_digit_roller.sv
// Self-checking bench for digit_roller: directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_digit_roller;

  localparam int TD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        run = 1'b0, step = 1'b0, load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] load_data = '0;
  logic [15:0] digits;
  logic [27:0] hex;
  logic        tick;
  logic [7:0]  step_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_dig;
  int          m_pcnt;
  int          m_cnt;
  logic [27:0] m_hex;

  digit_roller #(
    .NUM_DIGITS  (4),
    .TICK_DIV    (TD),
    .RESET_VALUE (16'h0123),
    .CNT_W       (8)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .run        (run),
    .step       (step),
    .mode       (mode),
    .load       (load),
    .load_data  (load_data),
    .digits     (digits),
    .hex        (hex),
    .tick       (tick),
    .step_count (step_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] hex_ref(input int d);
    return {seg_ref((d / 4096) % 16), seg_ref((d / 256) % 16),
            seg_ref((d / 16) % 16), seg_ref(d % 16)};
  endfunction

  function automatic int permute(input int d, input int md);
    case (md)
      1: return ((d * 16) % 65536) + (d / 4096);
      2: return (d / 16) + ((d % 16) * 4096);
      3: return ((d & 'h0F0F) * 16) + ((d & 'hF0F0) / 16);
      default: return d;
    endcase
  endfunction

  function automatic bit model_tick();
    return run && (m_pcnt == TD - 1);
  endfunction

  task automatic model_reset();
    m_dig = 16'h0123; m_pcnt = 0; m_cnt = 0; m_hex = '1;
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // cross the edge and settle.
  task automatic clk_step();
    bit tk;
    tk    = model_tick();
    m_hex = hex_ref(int'(m_dig));
    if (load) begin
      m_dig = load_data; m_pcnt = 0; m_cnt = 0;
    end else begin
      if (tk || step) begin
        m_dig = 16'(permute(int'(m_dig), int'(mode)));
        if (mode != 2'b00) m_cnt = (m_cnt + 1) % 256;
      end
      if (run) m_pcnt = (m_pcnt + 1) % TD;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    run = 0; step = 0; load = 0; mode = 2'b00;
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL reset_digits: got %h exp 0123", digits); end
    n_checks++; if (step_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", step_count); end
    n_checks++; if (hex !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_hex: got %h exp FFFFFFF", hex); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", tick); end
    RESET_N = 1'b1;
    model_reset();
    clk_step();
    n_checks++; if (hex[6:0] !== 7'h30) begin n_fail++; $display("FAIL reset_hex_d0: got %h exp 30", hex[6:0]); end
    n_checks++; if (hex[27:21] !== 7'h40) begin n_fail++; $display("FAIL reset_hex_d3: got %h exp 40", hex[27:21]); end
  endtask

  task automatic test_auto_rotate();
    do_reset();
    run = 1; mode = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_checks++; if (tick !== ((c % 4) == 0)) begin n_fail++; $display("FAIL auto_tick: cycle %0d got %b exp %b", c, tick, (c % 4) == 0); end
      clk_step();
      if (c == 4) begin
        n_checks++; if (digits !== 16'h1230) begin n_fail++; $display("FAIL auto_first: got %h exp 1230", digits); end
      end
    end
    n_checks++; if (digits !== 16'h2301) begin n_fail++; $display("FAIL auto_second: got %h exp 2301", digits); end
    n_checks++; if (step_count !== 8'd2) begin n_fail++; $display("FAIL auto_count: got %0d exp 2", step_count); end
    clk_step();
    n_checks++; if (hex !== hex_ref('h2301)) begin n_fail++; $display("FAIL auto_hex: got %h exp %h", hex, hex_ref('h2301)); end
  endtask

  task automatic test_manual_step();
    do_reset();
    mode = 2'b10; step = 1;
    #1;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL manual_tick: got %b exp 0", tick); end
    clk_step();
    step = 0;
    n_checks++; if (digits !== 16'h3012) begin n_fail++; $display("FAIL manual_rotr: got %h exp 3012", digits); end
    do_reset();
    run = 1; mode = 2'b01;
    repeat (3) clk_step();
    step = 1;
    #1;
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL coincide_tick: got %b exp 1", tick); end
    clk_step();
    step = 0; run = 0;
    n_checks++; if (digits !== 16'h1230) begin n_fail++; $display("FAIL coincide_digits: got %h exp 1230", digits); end
    n_checks++; if (step_count !== 8'd1) begin n_fail++; $display("FAIL coincide_count: got %0d exp 1", step_count); end
  endtask

  task automatic test_swap_hold();
    do_reset();
    mode = 2'b11; step = 1;
    clk_step();
    n_checks++; if (digits !== 16'h1032) begin n_fail++; $display("FAIL swap_first: got %h exp 1032", digits); end
    clk_step();
    n_checks++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL swap_second: got %h exp 0123", digits); end
    mode = 2'b00;
    repeat (3) clk_step();
    step = 0;
    n_checks++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL hold_digits: got %h exp 0123", digits); end
    n_checks++; if (step_count !== 8'd2) begin n_fail++; $display("FAIL hold_count: got %0d exp 2", step_count); end
  endtask

  task automatic test_load_priority();
    do_reset();
    run = 1; mode = 2'b01;
    repeat (2) clk_step();
    load = 1; load_data = 16'hABCD; step = 1;
    clk_step();
    load = 0; step = 0;
    n_checks++; if (digits !== 16'hABCD) begin n_fail++; $display("FAIL load_digits: got %h exp ABCD", digits); end
    n_checks++; if (step_count !== 8'd0) begin n_fail++; $display("FAIL load_count: got %0d exp 0", step_count); end
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++; if (tick !== (c == 4)) begin n_fail++; $display("FAIL load_tick: cycle %0d got %b exp %b", c, tick, c == 4); end
      clk_step();
    end
    run = 0;
    n_checks++; if (digits !== 16'hBCDA) begin n_fail++; $display("FAIL load_rot: got %h exp BCDA", digits); end
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 2'b01; step = 1;
    repeat (255) clk_step();
    n_checks++; if (step_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d exp 255", step_count); end
    clk_step();
    step = 0;
    n_checks++; if (step_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count: got %0d exp 0", step_count); end
    n_checks++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL wrap_digits: got %h exp 0123", digits); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run = 1; mode = 2'b01;
    repeat (6) clk_step();
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL midrst_digits: got %h exp 0123", digits); end
    n_checks++; if (step_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", step_count); end
    n_checks++; if (hex !== 28'hFFFFFFF) begin n_fail++; $display("FAIL midrst_hex: got %h exp FFFFFFF", hex); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick: got %b exp 0", tick); end
    run = 0;
    RESET_N = 1'b1;
    model_reset();
    @(posedge CLOCK_50);
    #1;
    m_hex = hex_ref('h0123);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      run       = ($urandom_range(3) != 0);
      step      = ($urandom_range(3) == 0);
      mode      = 2'($urandom_range(3));
      load      = ($urandom_range(19) == 0);
      load_data = 16'($urandom);
      #1;
      n_checks++; if (tick !== model_tick()) begin n_fail++; $display("FAIL rand_tick: cycle %0d got %b exp %b", c, tick, model_tick()); end
      clk_step();
      n_checks++; if (digits !== m_dig) begin n_fail++; $display("FAIL rand_digits: cycle %0d got %h exp %h", c, digits, m_dig); end
      n_checks++; if (step_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_count: cycle %0d got %0d exp %0d", c, step_count, m_cnt); end
      n_checks++; if (hex !== m_hex) begin n_fail++; $display("FAIL rand_hex: cycle %0d got %h exp %h", c, hex, m_hex); end
    end
    run = 0; step = 0; load = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_auto_rotate();
    test_manual_step();
    test_swap_hold();
    test_load_priority();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
